cpu6_lsu_ctrl: RTL and testbench
================================

# cpu6_lsu_ctrl

Load/store sequencer for the cpu6 memory stage. It takes the decoded `memtoreg`/`memwrite` controls, address and store data of the instruction in EX/MEM and runs one word access on the data bus through a request/response handshake. It stalls the pipeline while the access is outstanding and returns load data to writeback. It also reports misalignment and bus faults to the trap logic.

## Interface
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles, 1..255; used only when `CPU6_LSU_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `ex_valid` in 1: instruction in EX/MEM is valid.
- `ex_memtoreg` in 1: instruction is a load (lw).
- `ex_memwrite` in 1: instruction is a store (sw).
- `ex_flush` in 1: kill the current instruction (branch, jump, trap).
- `ex_addr` in 32: byte address from the ALU.
- `ex_wdata` in 32: store data (rs2).
- `ex_rd` in 5: load destination register.
- `bus_req` out 1: request valid.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address; bits [1:0] are always 0.
- `bus_wdata` out 32: write data.
- `bus_ready` in 1: request accepted in this cycle.
- `bus_rvalid` in 1: response valid (loads and stores).
- `bus_rdata` in 32: load data.
- `bus_err` in 1: response is an error; qualified by `bus_rvalid`.
- `stall` out 1: hold IF/ID/EX/MEM.
- `wb_valid` out 1: one-cycle load writeback.
- `wb_rd` out 5: writeback register.
- `wb_data` out 32: writeback data.
- `mem_done` out 1: one-cycle completion pulse for any access, including killed or faulted ones.
- `misaligned` out 1: combinational; misaligned access detected.
- `access_fault` out 1: one-cycle pulse for a bus error or timeout.

## Operation
- States: IDLE, REQ, RESP, DONE. Encoding is 2 bits; reset state is IDLE.
- `start = ex_valid & (ex_memtoreg | ex_memwrite) & ~ex_flush & (ex_addr[1:0]==0)`.
- `misaligned = ex_valid & (ex_memtoreg | ex_memwrite) & ~ex_flush & (ex_addr[1:0]!=0)`, evaluated in IDLE only.
  - A misaligned access issues no request and raises no stall.
  - If both `ex_memtoreg` and `ex_memwrite` are set, the access is treated as a store.
- IDLE → REQ on `start`. On the same edge the block latches address, data, `we = ex_memwrite`, `rd`, and clears `kill`.
- REQ:
  - `bus_req=1`; `bus_addr`/`bus_wdata`/`bus_we` come from the latches and stay stable until accepted.
  - `bus_ready` → RESP.
  - `ex_flush` without `bus_ready` → IDLE with no further effect; withdrawing an unaccepted request is legal.
  - `ex_flush` together with `bus_ready` → RESP with `kill=1`.
- RESP:
  - `bus_req=0`. `ex_flush` sets `kill`; the outstanding response is still awaited.
  - `bus_rvalid` → DONE. On that edge the block captures `bus_rdata` and records `err = bus_err`.
- DONE:
  - `mem_done=1`.
  - `wb_valid = ~we & ~kill & ~err`.
  - `access_fault = err & ~kill`.
  - → IDLE unconditionally.
- `stall = (IDLE & start) | REQ | RESP`. It is deasserted in DONE so the pipeline advances on that edge.
- `wb_rd` and `wb_data` hold their last values when `wb_valid=0`.

## Timing
- Reset: every output is 0; the latches are 0 and `kill=0`.
- Assertion of `resetn` mid-access forces IDLE immediately and drops `bus_req` asynchronously.
- Minimum latency, with `bus_ready` in the first REQ cycle and `bus_rvalid` one cycle later:
  - `start` at cycle 0, REQ at 1, RESP at 2, DONE at 3.
  - `stall` is high in cycles 0–2.
  - `wb_valid` is high in cycle 3.
- `bus_rvalid` is sampled only in RESP. A response in the same cycle as `bus_ready` is a protocol violation and is ignored.
- Only one access is outstanding at a time. No new `start` is accepted in DONE; the next access is taken from IDLE one cycle later.

## Configuration
- `CPU6_LSU_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches `TIMEOUT_CYCLES`, the block goes to DONE with `err=1`: `access_fault` pulses (unless `kill`) and `bus_req` drops.
  - A later stray `bus_rvalid` is ignored in IDLE.
- Not defined: no counter is built, and the block waits indefinitely in REQ or RESP.

## Test plan
- Load, addr 0x100: `bus_ready` in cycle 1, `bus_rvalid` in cycle 2 with rdata 0xDEADBEEF, rd=5 → `stall` high in cycles 0–2; `wb_valid` in cycle 3 with rd=5 and data 0xDEADBEEF; `mem_done=1`.
- Store, addr 0x204, wdata 0x12345678: `bus_ready` held low for 3 cycles → `bus_req`/`bus_addr`/`bus_wdata` stable for all 4 REQ cycles, `bus_we=1`, `mem_done` at completion, `wb_valid=0`.
- Load at 0x102 → `misaligned=1` in the same cycle; no `bus_req`, `stall=0`, state stays IDLE.
- `ex_flush` in REQ without `bus_ready` → `bus_req` low on the next cycle, back in IDLE, no `mem_done`. `ex_flush` in RESP → wait for `bus_rvalid`, then `mem_done=1`, `wb_valid=0`, `access_fault=0`.
- Load whose response has `bus_rvalid=1, bus_err=1` → `access_fault` pulse in DONE, `wb_valid=0`.
- With `CPU6_LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, `bus_ready` never asserted → `access_fault` four cycles after entering REQ; then `stall=0` and IDLE.

Source files
------------

// File: rtl/cpu6_lsu_ctrl.sv
// cpu6 memory-stage load/store sequencer: one word access per instruction over a req/resp bus.
// Optional watchdog enabled by defining CPU6_LSU_TIMEOUT_EN.
module cpu6_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        ex_memtoreg,
  input  logic        ex_memwrite,
  input  logic        ex_flush,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_done,
  output logic        misaligned,
  output logic        access_fault
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic        kill_q, kill_d;
  logic        err_q, err_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic is_mem, aligned, start, timeout, kill_nxt;

  assign is_mem  = ex_valid & (ex_memtoreg | ex_memwrite) & ~ex_flush;
  assign aligned = (ex_addr[1:0] == 2'b00);
  assign start   = is_mem & aligned;

`ifdef CPU6_LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = 8'd0;
    end else if (state_q == StReq || state_q == StResp) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign timeout = (state_q == StReq || state_q == StResp) &&
                   (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rd_d      = rd_q;
    kill_d    = kill_q;
    err_d     = err_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    kill_nxt  = kill_q | ex_flush;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          addr_d  = ex_addr[31:2];
          wdata_d = ex_wdata;
          we_d    = ex_memwrite;
          rd_d    = ex_rd;
          kill_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StReq: begin
        if (bus_ready) begin
          state_d = StResp;
          kill_d  = kill_nxt;
        end else if (ex_flush) begin
          // An unaccepted request can simply be withdrawn.
          state_d = StIdle;
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        kill_d = kill_nxt;
        if (bus_rvalid) begin
          state_d = StDone;
          err_d   = bus_err;
          if (!we_q && !kill_nxt && !bus_err) begin
            wb_rd_d   = rd_q;
            wb_data_d = bus_rdata;
          end
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= 30'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      kill_q    <= 1'b0;
      err_q     <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      kill_q    <= kill_d;
      err_q     <= err_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus_req      = (state_q == StReq);
  assign bus_we       = we_q;
  assign bus_addr     = {addr_q, 2'b00};
  assign bus_wdata    = wdata_q;
  assign stall        = ((state_q == StIdle) & start) | (state_q == StReq) | (state_q == StResp);
  assign misaligned   = (state_q == StIdle) & is_mem & ~aligned;
  assign mem_done     = (state_q == StDone);
  assign wb_valid     = mem_done & ~we_q & ~kill_q & ~err_q;
  assign access_fault = mem_done & err_q & ~kill_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_cpu6_lsu_ctrl.sv
// Directed bench for cpu6_lsu_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_cpu6_lsu_ctrl;

  logic        clk, resetn;
  logic        ex_valid, ex_memtoreg, ex_memwrite, ex_flush;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;
  logic        stall, wb_valid, mem_done, misaligned, access_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  cpu6_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_flush(ex_flush), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_done(mem_done), .misaligned(misaligned), .access_fault(access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v, ld, st, fl;
    logic [31:0] addr, wdata;
    logic [4:0] rd;
    logic rdy, rvld;
    logic [31:0] rdata;
    logic err;
    logic req, we;
    logic [31:0] baddr, bwdata;
    logic stl, wbv;
    logic [4:0] wbrd;
    logic [31:0] wbdata;
    logic done, mis, fault;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, ld, st, fl, input logic [31:0] addr, wdata,
                     input logic [4:0] rd, input logic rdy, rvld, input logic [31:0] rdata,
                     input logic err, input logic req, we, input logic [31:0] baddr, bwdata,
                     input logic stl, wbv, input logic [4:0] wbrd, input logic [31:0] wbdata,
                     input logic done, mis, fault);
    vec_t t;
    t.v = v; t.ld = ld; t.st = st; t.fl = fl; t.addr = addr; t.wdata = wdata; t.rd = rd;
    t.rdy = rdy; t.rvld = rvld; t.rdata = rdata; t.err = err;
    t.req = req; t.we = we; t.baddr = baddr; t.bwdata = bwdata; t.stl = stl; t.wbv = wbv;
    t.wbrd = wbrd; t.wbdata = wbdata; t.done = done; t.mis = mis; t.fault = fault;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_ex(input logic v, ld, st, fl, input logic [31:0] addr, wdata,
                          input logic [4:0] rd);
    ex_valid = v; ex_memtoreg = ld; ex_memwrite = st; ex_flush = fl;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
  endtask

  task automatic drive_bus(input logic rdy, rvld, input logic [31:0] rdata, input logic err);
    bus_ready = rdy; bus_rvalid = rvld; bus_rdata = rdata; bus_err = err;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    drive_bus(0, 0, 0, 0);
    #3;
    chk("reset bus_req", bus_req, 0);
    chk("reset stall", stall, 0);
    chk("reset bus_addr", bus_addr, 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset mem_done", mem_done, 0);
    chk("reset wb_valid", wb_valid, 0);

    // Load 0x100 rd5, minimum latency.
    add(1,1,0,0,'h100,0,5, 0,0,0,0, 0,0,'h000,0, 1,0,0,0, 0,0,0);
    add(1,1,0,0,'h100,0,5, 1,0,0,0, 1,0,'h100,0, 1,0,0,0, 0,0,0);
    add(1,1,0,0,'h100,0,5, 0,1,'hDEADBEEF,0, 0,0,'h100,0, 1,0,0,0, 0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h100,0, 0,1,5,'hDEADBEEF, 1,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h100,0, 0,0,5,'hDEADBEEF, 0,0,0);
    // Misaligned load/store, and flushed accesses.
    add(1,1,0,0,'h102,0,7, 0,0,0,0, 0,0,'h100,0, 0,0,5,'hDEADBEEF, 0,1,0);
    add(1,0,1,0,'h203,0,0, 0,0,0,0, 0,0,'h100,0, 0,0,5,'hDEADBEEF, 0,1,0);
    add(1,1,0,1,'h102,0,0, 0,0,0,0, 0,0,'h100,0, 0,0,5,'hDEADBEEF, 0,0,0);
    add(1,0,1,1,'h600,0,0, 0,0,0,0, 0,0,'h100,0, 0,0,5,'hDEADBEEF, 0,0,0);
    // Load with bus error.
    add(1,1,0,0,'h300,0,9, 0,0,0,0, 0,0,'h100,0, 1,0,5,'hDEADBEEF, 0,0,0);
    add(1,1,0,0,'h300,0,9, 1,0,0,0, 1,0,'h300,0, 1,0,5,'hDEADBEEF, 0,0,0);
    add(1,1,0,0,'h300,0,9, 0,1,'h0BAD,1, 0,0,'h300,0, 1,0,5,'hDEADBEEF, 0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h300,0, 0,0,5,'hDEADBEEF, 1,0,1);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h300,0, 0,0,5,'hDEADBEEF, 0,0,0);
    // rvalid alongside ready is ignored.
    add(1,1,0,0,'h400,0,3, 0,0,0,0, 0,0,'h300,0, 1,0,5,'hDEADBEEF, 0,0,0);
    add(1,1,0,0,'h400,0,3, 1,1,'h11111111,0, 1,0,'h400,0, 1,0,5,'hDEADBEEF, 0,0,0);
    add(1,1,0,0,'h400,0,3, 0,0,0,0, 0,0,'h400,0, 1,0,5,'hDEADBEEF, 0,0,0);
    add(1,1,0,0,'h400,0,3, 0,1,'h22222222,0, 0,0,'h400,0, 1,0,5,'hDEADBEEF, 0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,'h400,0, 0,1,3,'h22222222, 1,0,0);
    // memtoreg and memwrite both set: treated as a store.
    add(1,1,1,0,'h500,'hA5A5A5A5,4, 0,0,0,0, 0,0,'h400,0, 1,0,3,'h22222222, 0,0,0);
    add(1,1,1,0,'h500,'hA5A5A5A5,4, 1,0,0,0, 1,1,'h500,'hA5A5A5A5, 1,0,3,'h22222222, 0,0,0);
    add(1,1,1,0,'h500,'hA5A5A5A5,4, 0,1,'h33333333,0, 0,1,'h500,'hA5A5A5A5, 1,0,3,'h22222222,
        0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,1,'h500,'hA5A5A5A5, 0,0,3,'h22222222, 1,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,1,'h500,'hA5A5A5A5, 0,0,3,'h22222222, 0,0,0);

    nxt();
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_ex(vecs[i].v, vecs[i].ld, vecs[i].st, vecs[i].fl, vecs[i].addr, vecs[i].wdata,
               vecs[i].rd);
      drive_bus(vecs[i].rdy, vecs[i].rvld, vecs[i].rdata, vecs[i].err);
      @(negedge clk);
      chk($sformatf("v%0d bus_req", i), bus_req, vecs[i].req);
      chk($sformatf("v%0d bus_we", i), bus_we, vecs[i].we);
      chk($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].baddr);
      chk($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].bwdata);
      chk($sformatf("v%0d stall", i), stall, vecs[i].stl);
      chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].wbv);
      chk($sformatf("v%0d wb_rd", i), wb_rd, vecs[i].wbrd);
      chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].wbdata);
      chk($sformatf("v%0d mem_done", i), mem_done, vecs[i].done);
      chk($sformatf("v%0d misaligned", i), misaligned, vecs[i].mis);
      chk($sformatf("v%0d access_fault", i), access_fault, vecs[i].fault);
      nxt();
    end

    // Store 0x204 with ready held off for three REQ cycles.
    drive_ex(1, 0, 1, 0, 'h204, 'h12345678, 0);
    drive_bus(0, 0, 0, 0);
    @(negedge clk);
    chk("st start stall", stall, 1);
    nxt();
    for (int i = 0; i < 4; i++) begin
      drive_bus(i == 3, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("st req%0d bus_req", i), bus_req, 1);
      chk($sformatf("st req%0d bus_we", i), bus_we, 1);
      chk($sformatf("st req%0d bus_addr", i), bus_addr, 'h204);
      chk($sformatf("st req%0d bus_wdata", i), bus_wdata, 'h12345678);
      chk($sformatf("st req%0d stall", i), stall, 1);
      nxt();
    end
    drive_bus(0, 1, 0, 0);
    @(negedge clk);
    chk("st resp bus_req", bus_req, 0);
    chk("st resp mem_done", mem_done, 0);
    nxt();
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    drive_bus(0, 0, 0, 0);
    @(negedge clk);
    chk("st done mem_done", mem_done, 1);
    chk("st done wb_valid", wb_valid, 0);
    chk("st done stall", stall, 0);
    nxt();

    // Flush while the request is still unaccepted.
    drive_ex(1, 1, 0, 0, 'h700, 0, 6);
    nxt();
    drive_ex(1, 1, 0, 1, 'h700, 0, 6);
    @(negedge clk);
    chk("flreq bus_req", bus_req, 1);
    nxt();
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("flreq after%0d bus_req", i), bus_req, 0);
      chk($sformatf("flreq after%0d stall", i), stall, 0);
      chk($sformatf("flreq after%0d mem_done", i), mem_done, 0);
      nxt();
    end

    // Flush while the response is outstanding.
    drive_ex(1, 1, 0, 0, 'h800, 0, 8);
    nxt();
    drive_bus(1, 0, 0, 0);
    nxt();
    drive_ex(1, 1, 0, 1, 'h800, 0, 8);
    drive_bus(0, 0, 0, 0);
    @(negedge clk);
    chk("flresp wait stall", stall, 1);
    nxt();
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    drive_bus(0, 1, 'h44444444, 0);
    @(negedge clk);
    chk("flresp rvalid stall", stall, 1);
    nxt();
    drive_bus(0, 0, 0, 0);
    @(negedge clk);
    chk("flresp mem_done", mem_done, 1);
    chk("flresp wb_valid", wb_valid, 0);
    chk("flresp access_fault", access_fault, 0);
    chk("flresp wb_data held", wb_data, 'h22222222);
    nxt();

    // Asynchronous reset in the middle of a request.
    drive_ex(1, 1, 0, 0, 'h900, 0, 2);
    nxt();
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("arst pre bus_req", bus_req, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst bus_req", bus_req, 0);
    chk("arst stall", stall, 0);
    chk("arst bus_addr", bus_addr, 0);
    chk("arst wb_rd", wb_rd, 0);
    nxt();
    resetn = 1'b1;
    @(negedge clk);
    chk("arst idle bus_req", bus_req, 0);
    nxt();

`ifdef CPU6_LSU_TIMEOUT_EN
    // Watchdog: ready never comes.
    drive_ex(1, 1, 0, 0, 'hA00, 0, 1);
    nxt();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("to req%0d bus_req", i), bus_req, 1);
      chk($sformatf("to req%0d access_fault", i), access_fault, 0);
      nxt();
    end
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("to done access_fault", access_fault, 1);
    chk("to done mem_done", mem_done, 1);
    chk("to done bus_req", bus_req, 0);
    chk("to done stall", stall, 0);
    nxt();
    drive_bus(0, 1, 'h55555555, 0);
    @(negedge clk);
    chk("to stray mem_done", mem_done, 0);
    chk("to stray wb_valid", wb_valid, 0);
    nxt();
    drive_bus(0, 0, 0, 0);
    @(negedge clk);
    chk("to idle mem_done", mem_done, 0);
    chk("to idle stall", stall, 0);
    nxt();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
